sop_sweep_ctrl: RTL and testbench

- Sequencer for a 4-input combinational sum-of-products block (inputs a,b,c,d; output f).
- On start, drives all 16 input vectors in ascending order and samples the function output for each.
- Assembles the sampled values into a 16-bit truth table and compares it bit-by-bit against an expected mask.
- Reports busy, done, mismatch count and pass. Used for built-in self-check of SOP/POS gate-level blocks.

---
 rtl/sop_ctrl_pkg.sv | 14 +
 rtl/sop_settle_timer.sv | 37 +++
 rtl/sop_sweep_ctrl.sv | 118 +++++++++++
 tb/tb_sop_sweep_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sop_ctrl_pkg.sv
// Shared types and sizes for the SOP truth-table sweep sequencer.
package sop_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        FINISH
    } state_e;

    localparam int unsigned NUM_VEC = 16;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned MCNT_W  = 5;

endpackage

// File: rtl/sop_settle_timer.sv
// Loadable down-counter that sets how long each vector is held before sampling.
module sop_settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 0,
    parameter int unsigned CNT_W         = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/sop_sweep_ctrl.sv
// Drives all 16 input vectors into an SOP block, captures its truth table and
// compares it against a latched golden mask.
module sop_sweep_ctrl
    import sop_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 0,
    parameter int unsigned CNT_W         = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    output logic [3:0]  abcd_o,
    input  logic        f_i,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_cnt,
    output logic        pass
);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [15:0]         exp_q, exp_d;
    logic [15:0]         tt_q, tt_d;
    logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                tmr_load;
    logic                tmr_en;
    logic                tmr_zero;

    sop_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .en    (tmr_en),
        .zero  (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        exp_d    = exp_q;
        tt_d     = tt_q;
        mcnt_d   = mcnt_q;
        busy_d   = busy_q;
        done_d   = done_q;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;

        unique case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    state_d  = SWEEP;
                    idx_d    = '0;
                    exp_d    = expected;
                    tt_d     = '0;
                    mcnt_d   = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            SWEEP: begin
                if (!tmr_zero) begin
                    tmr_en = 1'b1;
                end else begin
                    tt_d[idx_q] = f_i;
                    mcnt_d      = mcnt_q + MCNT_W'(f_i != exp_q[idx_q]);
                    tmr_load    = 1'b1;
                    // idx doubles as the driven vector, so clearing it on the
                    // last sample is what returns abcd_o to 0 in FINISH.
                    if (idx_q == IDX_W'(NUM_VEC - 1)) begin
                        state_d = FINISH;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            exp_q   <= '0;
            tt_q    <= '0;
            mcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            mcnt_q  <= mcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign abcd_o       = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign truth_table  = tt_q;
    assign mismatch_cnt = mcnt_q;
    assign pass         = done_q && (mcnt_q == '0);

endmodule

// File: tb/tb_sop_sweep_ctrl.sv
// Self-checking bench: two sequencer instances (settle 0 and 3) each driving a
// behavioural SOP block; table-driven sweeps plus reset corner sequences.
module tb_sop_sweep_ctrl;

    localparam logic [15:0] GOLD    = 16'hC4F4;
    localparam int unsigned BOUND   = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        start_s [2];
    logic [15:0] exp_s   [2];
    logic [3:0]  abcd_s  [2];
    logic        f_s     [2];
    logic        busy_s  [2];
    logic        done_s  [2];
    logic [15:0] tt_s    [2];
    logic [4:0]  mc_s    [2];
    logic        pass_s  [2];
    int unsigned mode_s  [2];

    logic [3:0]  sbq0 [$];
    logic [3:0]  sbq1 [$];

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    typedef struct {
        int unsigned sel;
        int unsigned mode;     // 0 golden, 1 stuck-at-0, 2 inverted
        logic [15:0] expected;
        logic        inject;   // mid-sweep expected change and stray start
        logic [15:0] tt;
        logic [4:0]  mc;
        logic        pass;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    // f = a'b + cd' + abc
    function automatic logic sop_f(input logic [3:0] v, input int unsigned mode);
        logic a, b, c, d, g;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        g = (!a && b) || (c && !d) || (a && b && c);
        case (mode)
            1:       return 1'b0;
            2:       return !g;
            default: return g;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sop_sweep_ctrl #(
            .SETTLE_CYCLES ((g == 0) ? 0 : 3),
            .CNT_W         (4)
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .start        (start_s[g]),
            .expected     (exp_s[g]),
            .abcd_o       (abcd_s[g]),
            .f_i          (f_s[g]),
            .busy         (busy_s[g]),
            .done         (done_s[g]),
            .truth_table  (tt_s[g]),
            .mismatch_cnt (mc_s[g]),
            .pass         (pass_s[g])
        );
        assign f_s[g] = sop_f(abcd_s[g], mode_s[g]);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic sb_pop_check(input int unsigned sel);
        logic [3:0] e;
        int unsigned sz;
        sz = (sel == 0) ? sbq0.size() : sbq1.size();
        if (sz == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = (sel == 0) ? sbq0.pop_front() : sbq1.pop_front();
            chk("abcd_seq", {28'd0, abcd_s[sel]}, {28'd0, e});
        end
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned settle, hold, n, sz;
        logic        got_done;
        settle = (v.sel == 0) ? 0 : 3;
        hold   = 16 * (settle + 1);
        @(negedge clk);
        mode_s[v.sel]  = v.mode;
        exp_s[v.sel]   = v.expected;
        start_s[v.sel] = 1'b1;
        for (int vi = 0; vi < 16; vi++) begin
            for (int r = 0; r <= int'(settle); r++) begin
                if (v.sel == 0) sbq0.push_back(4'(vi));
                else            sbq1.push_back(4'(vi));
            end
        end
        @(negedge clk);
        start_s[v.sel] = 1'b0;
        chk("accept_done_low", {31'd0, done_s[v.sel]}, 32'd0);
        chk("accept_tt_clear", {16'd0, tt_s[v.sel]}, 32'd0);
        chk("accept_mc_clear", {27'd0, mc_s[v.sel]}, 32'd0);
        chk("accept_busy", {31'd0, busy_s[v.sel]}, 32'd1);
        n = 1;
        got_done = 1'b0;
        while (n <= BOUND) begin
            if (done_s[v.sel]) begin
                got_done = 1'b1;
                break;
            end
            if (busy_s[v.sel]) sb_pop_check(v.sel);
            else chk("busy_during_sweep", 32'd0, 32'd1);
            @(negedge clk);
            n++;
            if (v.inject) begin
                if (n == 10) exp_s[v.sel] = 16'hFFFF;
                if (n == 20) start_s[v.sel] = 1'b1;
                if (n == 21) start_s[v.sel] = 1'b0;
            end
        end
        chk("done_reached", {31'd0, got_done}, 32'd1);
        chk("done_latency", n - 1, hold);
        chk("truth_table", {16'd0, tt_s[v.sel]}, {16'd0, v.tt});
        chk("mismatch_cnt", {27'd0, mc_s[v.sel]}, {27'd0, v.mc});
        chk("pass", {31'd0, pass_s[v.sel]}, {31'd0, v.pass});
        chk("finish_busy", {31'd0, busy_s[v.sel]}, 32'd0);
        chk("finish_abcd", {28'd0, abcd_s[v.sel]}, 32'd0);
        sz = (v.sel == 0) ? sbq0.size() : sbq1.size();
        chk("sb_drained", sz, 32'd0);
    endtask

    initial begin
        vecs[0] = '{sel: 0, mode: 0, expected: GOLD,     inject: 1'b0, tt: GOLD,     mc: 5'd0,  pass: 1'b1};
        vecs[1] = '{sel: 0, mode: 1, expected: GOLD,     inject: 1'b0, tt: 16'h0000, mc: 5'd8,  pass: 1'b0};
        vecs[2] = '{sel: 0, mode: 2, expected: GOLD,     inject: 1'b0, tt: 16'h3B0B, mc: 5'd16, pass: 1'b0};
        vecs[3] = '{sel: 1, mode: 0, expected: GOLD,     inject: 1'b1, tt: GOLD,     mc: 5'd0,  pass: 1'b1};
        vecs[4] = '{sel: 0, mode: 0, expected: 16'h0000, inject: 1'b0, tt: GOLD,     mc: 5'd8,  pass: 1'b0};
        vecs[5] = '{sel: 0, mode: 0, expected: GOLD,     inject: 1'b0, tt: GOLD,     mc: 5'd0,  pass: 1'b1};

        for (int g = 0; g < 2; g++) begin
            start_s[g] = 1'b0;
            exp_s[g]   = GOLD;
            mode_s[g]  = 0;
        end

        // Asynchronous reset before any clock edge, then held with start high.
        #2 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_abcd", {28'd0, abcd_s[g]}, 32'd0);
            chk("rst_busy", {31'd0, busy_s[g]}, 32'd0);
            chk("rst_done", {31'd0, done_s[g]}, 32'd0);
            chk("rst_tt", {16'd0, tt_s[g]}, 32'd0);
            chk("rst_mc", {27'd0, mc_s[g]}, 32'd0);
            chk("rst_pass", {31'd0, pass_s[g]}, 32'd0);
            start_s[g] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk("rst_hold_busy", {31'd0, busy_s[g]}, 32'd0);
            chk("rst_hold_abcd", {28'd0, abcd_s[g]}, 32'd0);
        end
        @(negedge clk);
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Reset landing mid-sweep while vector 7 is driven.
        @(negedge clk);
        mode_s[0]  = 0;
        exp_s[0]   = GOLD;
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (7) @(negedge clk);
        chk("pre_rst_idx7", {28'd0, abcd_s[0]}, 32'd7);
        chk("pre_rst_busy", {31'd0, busy_s[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_abcd", {28'd0, abcd_s[0]}, 32'd0);
        chk("midrst_busy", {31'd0, busy_s[0]}, 32'd0);
        chk("midrst_tt", {16'd0, tt_s[0]}, 32'd0);
        chk("midrst_done", {31'd0, done_s[0]}, 32'd0);
        chk("midrst_mc", {27'd0, mc_s[0]}, 32'd0);
        sbq0.delete();
        @(negedge clk);
        rst_n = 1'b1;

        run_vec(vecs[5]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
